id_ex_stage_reg: RTL and testbench

- Decode-to-execute pipeline register for the 5-stage MIPS core, with stall/bubble generation built in.
- Captures the decode-stage operands and control each cycle and presents the E-stage fields (Rs_E, Rt_E, Write_Reg_E, Reg_Write_E, ...) to the forwarding unit and the ALU.
- Detects load-use and branch-compare hazards that forwarding cannot cover. On a hazard it stalls F/D and injects a bubble into E.
- Keeps a saturating stall counter and a sticky stall-timeout flag for debug.

---
 rtl/id_ex_stage_reg.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use / branch-compare hazard detection,
// bubble injection into E, and a saturating stall counter with a sticky timeout flag.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STALL_CNT_W = 16,
    parameter int unsigned MAX_STALL   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Valid_D,
    input  logic [4:0]             Rs_D,
    input  logic [4:0]             Rt_D,
    input  logic [4:0]             Rd_D,
    input  logic [DATA_W-1:0]      Read_Data1_D,
    input  logic [DATA_W-1:0]      Read_Data2_D,
    input  logic [DATA_W-1:0]      Sign_Imm_D,
    input  logic                   Reg_Write_D,
    input  logic                   Mem_To_Reg_D,
    input  logic                   Mem_Write_D,
    input  logic                   ALU_Src_D,
    input  logic                   Reg_Dst_D,
    input  logic                   Branch_D,
    input  logic [2:0]             ALU_Control_D,
    input  logic [4:0]             Write_Reg_M,
    input  logic                   Mem_To_Reg_M,
    output logic                   Valid_E,
    output logic                   Reg_Write_E,
    output logic                   Mem_To_Reg_E,
    output logic                   Mem_Write_E,
    output logic                   ALU_Src_E,
    output logic                   Reg_Dst_E,
    output logic [2:0]             ALU_Control_E,
    output logic [4:0]             Rs_E,
    output logic [4:0]             Rt_E,
    output logic [4:0]             Rd_E,
    output logic [DATA_W-1:0]      Read_Data1_E,
    output logic [DATA_W-1:0]      Read_Data2_E,
    output logic [DATA_W-1:0]      Sign_Imm_E,
    output logic [4:0]             Write_Reg_E,
    output logic                   Stall_F,
    output logic                   Stall_D,
    output logic                   Flush_E,
    output logic [STALL_CNT_W-1:0] Stall_Count,
    output logic                   Stall_Error
);

    localparam int unsigned CONS_W = $clog2(MAX_STALL + 2);
    localparam logic [CONS_W-1:0] MaxStallC = CONS_W'(MAX_STALL);

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              mem_write_q, mem_write_d;
    logic              alu_src_q, alu_src_d;
    logic              reg_dst_q, reg_dst_d;
    logic [2:0]        alu_control_q, alu_control_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CONS_W-1:0] cons_q, cons_d;
    logic              err_q, err_d;

    logic       lw_stall, branch_stall, haz_e, haz_m, flush;
    logic [4:0] write_reg_e;

    always_comb begin
        write_reg_e = reg_dst_q ? rd_q : rt_q;
        lw_stall = Valid_D & valid_q & mem_to_reg_q & (rt_q != 5'd0) &
                   ((rt_q == Rs_D) | (rt_q == Rt_D));
        haz_e = reg_write_q & (write_reg_e != 5'd0) &
                ((write_reg_e == Rs_D) | (write_reg_e == Rt_D));
        haz_m = Mem_To_Reg_M & (Write_Reg_M != 5'd0) &
                ((Write_Reg_M == Rs_D) | (Write_Reg_M == Rt_D));
        branch_stall = Valid_D & Branch_D & (haz_e | haz_m);
        flush = lw_stall | branch_stall;
    end

    always_comb begin
        // Bubble by default; identifiers cleared so forwarding never matches it.
        valid_d       = 1'b0;
        reg_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        mem_write_d   = 1'b0;
        alu_src_d     = 1'b0;
        reg_dst_d     = 1'b0;
        alu_control_d = 3'd0;
        rs_d          = 5'd0;
        rt_d          = 5'd0;
        rd_d          = 5'd0;
        rd1_d         = '0;
        rd2_d         = '0;
        imm_d         = '0;
        if (!flush) begin
            valid_d       = Valid_D;
            reg_write_d   = Reg_Write_D & Valid_D;
            mem_to_reg_d  = Mem_To_Reg_D & Valid_D;
            mem_write_d   = Mem_Write_D & Valid_D;
            alu_src_d     = ALU_Src_D;
            reg_dst_d     = Reg_Dst_D;
            alu_control_d = ALU_Control_D;
            rs_d          = Rs_D;
            rt_d          = Rt_D;
            rd_d          = Rd_D;
            rd1_d         = Read_Data1_D;
            rd2_d         = Read_Data2_D;
            imm_d         = Sign_Imm_D;
        end

        stall_cnt_d = stall_cnt_q;
        if (flush && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end

        cons_d = '0;
        if (flush) begin
            cons_d = (cons_q == MaxStallC) ? cons_q : cons_q + CONS_W'(1);
        end
        // Counter already at the limit means this edge is stall MAX_STALL+1.
        err_d = err_q | (flush & (cons_q == MaxStallC));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            alu_src_q     <= 1'b0;
            reg_dst_q     <= 1'b0;
            alu_control_q <= 3'd0;
            rs_q          <= 5'd0;
            rt_q          <= 5'd0;
            rd_q          <= 5'd0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
            stall_cnt_q   <= '0;
            cons_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            mem_write_q   <= mem_write_d;
            alu_src_q     <= alu_src_d;
            reg_dst_q     <= reg_dst_d;
            alu_control_q <= alu_control_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            imm_q         <= imm_d;
            stall_cnt_q   <= stall_cnt_d;
            cons_q        <= cons_d;
            err_q         <= err_d;
        end
    end

    assign Valid_E       = valid_q;
    assign Reg_Write_E   = reg_write_q;
    assign Mem_To_Reg_E  = mem_to_reg_q;
    assign Mem_Write_E   = mem_write_q;
    assign ALU_Src_E     = alu_src_q;
    assign Reg_Dst_E     = reg_dst_q;
    assign ALU_Control_E = alu_control_q;
    assign Rs_E          = rs_q;
    assign Rt_E          = rt_q;
    assign Rd_E          = rd_q;
    assign Read_Data1_E  = rd1_q;
    assign Read_Data2_E  = rd2_q;
    assign Sign_Imm_E    = imm_q;
    assign Write_Reg_E   = write_reg_e;
    assign Stall_F       = flush;
    assign Stall_D       = flush;
    assign Flush_E       = flush;
    assign Stall_Count   = stall_cnt_q;
    assign Stall_Error   = err_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Table-driven bench for id_ex_stage_reg: per-cycle vectors plus hand sequences
// for reset, stall timeout and counter saturation (second instance, 2-bit counter).
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        Valid_D;
    logic [4:0]  Rs_D, Rt_D, Rd_D;
    logic [31:0] Read_Data1_D, Read_Data2_D, Sign_Imm_D;
    logic        Reg_Write_D, Mem_To_Reg_D, Mem_Write_D, ALU_Src_D, Reg_Dst_D, Branch_D;
    logic [2:0]  ALU_Control_D;
    logic [4:0]  Write_Reg_M;
    logic        Mem_To_Reg_M;

    logic        Valid_E, Reg_Write_E, Mem_To_Reg_E, Mem_Write_E, ALU_Src_E, Reg_Dst_E;
    logic [2:0]  ALU_Control_E;
    logic [4:0]  Rs_E, Rt_E, Rd_E, Write_Reg_E;
    logic [31:0] Read_Data1_E, Read_Data2_E, Sign_Imm_E;
    logic        Stall_F, Stall_D, Flush_E, Stall_Error;
    logic [15:0] Stall_Count;

    logic        s_valid_e, s_rw_e, s_mtr_e, s_mw_e, s_alusrc_e, s_regdst_e;
    logic [2:0]  s_alu_e;
    logic [4:0]  s_rs_e, s_rt_e, s_rd_e, s_wr_e;
    logic [31:0] s_rd1_e, s_rd2_e, s_imm_e;
    logic        s_stall_f, s_stall_d, s_flush_e, s_err;
    logic [1:0]  s_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .Valid_D(Valid_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
        .Read_Data1_D(Read_Data1_D), .Read_Data2_D(Read_Data2_D), .Sign_Imm_D(Sign_Imm_D),
        .Reg_Write_D(Reg_Write_D), .Mem_To_Reg_D(Mem_To_Reg_D), .Mem_Write_D(Mem_Write_D),
        .ALU_Src_D(ALU_Src_D), .Reg_Dst_D(Reg_Dst_D), .Branch_D(Branch_D),
        .ALU_Control_D(ALU_Control_D), .Write_Reg_M(Write_Reg_M), .Mem_To_Reg_M(Mem_To_Reg_M),
        .Valid_E(Valid_E), .Reg_Write_E(Reg_Write_E), .Mem_To_Reg_E(Mem_To_Reg_E),
        .Mem_Write_E(Mem_Write_E), .ALU_Src_E(ALU_Src_E), .Reg_Dst_E(Reg_Dst_E),
        .ALU_Control_E(ALU_Control_E), .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E),
        .Read_Data1_E(Read_Data1_E), .Read_Data2_E(Read_Data2_E), .Sign_Imm_E(Sign_Imm_E),
        .Write_Reg_E(Write_Reg_E), .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_E(Flush_E),
        .Stall_Count(Stall_Count), .Stall_Error(Stall_Error)
    );

    id_ex_stage_reg #(.DATA_W(32), .STALL_CNT_W(2), .MAX_STALL(4)) dut_small (
        .clk(clk), .rst(rst), .Valid_D(Valid_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
        .Read_Data1_D(Read_Data1_D), .Read_Data2_D(Read_Data2_D), .Sign_Imm_D(Sign_Imm_D),
        .Reg_Write_D(Reg_Write_D), .Mem_To_Reg_D(Mem_To_Reg_D), .Mem_Write_D(Mem_Write_D),
        .ALU_Src_D(ALU_Src_D), .Reg_Dst_D(Reg_Dst_D), .Branch_D(Branch_D),
        .ALU_Control_D(ALU_Control_D), .Write_Reg_M(Write_Reg_M), .Mem_To_Reg_M(Mem_To_Reg_M),
        .Valid_E(s_valid_e), .Reg_Write_E(s_rw_e), .Mem_To_Reg_E(s_mtr_e),
        .Mem_Write_E(s_mw_e), .ALU_Src_E(s_alusrc_e), .Reg_Dst_E(s_regdst_e),
        .ALU_Control_E(s_alu_e), .Rs_E(s_rs_e), .Rt_E(s_rt_e), .Rd_E(s_rd_e),
        .Read_Data1_E(s_rd1_e), .Read_Data2_E(s_rd2_e), .Sign_Imm_E(s_imm_e),
        .Write_Reg_E(s_wr_e), .Stall_F(s_stall_f), .Stall_D(s_stall_d), .Flush_E(s_flush_e),
        .Stall_Count(s_cnt), .Stall_Error(s_err)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1;
        logic        rw, mtr, mw, regdst, branch;
        logic [4:0]  wrm;
        logic        mtrm;
        logic        x_flush;
        logic        x_valid, x_rw, x_mtr;
        logic [4:0]  x_wr, x_rs, x_rt;
        logic [31:0] x_rd1;
        logic [15:0] x_cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [31:0] rd1, input logic rw, input logic mtr, input logic mw,
        input logic regdst, input logic br, input logic [4:0] wrm, input logic mtrm,
        input logic xf, input logic xv, input logic xrw, input logic xmtr,
        input logic [4:0] xwr, input logic [4:0] xrs, input logic [4:0] xrt,
        input logic [31:0] xrd1, input logic [15:0] xcnt);
        vec_t t;
        t.valid = v; t.rs = rs; t.rt = rt; t.rd = rd; t.rd1 = rd1;
        t.rw = rw; t.mtr = mtr; t.mw = mw; t.regdst = regdst; t.branch = br;
        t.wrm = wrm; t.mtrm = mtrm; t.x_flush = xf; t.x_valid = xv; t.x_rw = xrw;
        t.x_mtr = xmtr; t.x_wr = xwr; t.x_rs = xrs; t.x_rt = xrt; t.x_rd1 = xrd1;
        t.x_cnt = xcnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Valid_D = v.valid; Rs_D = v.rs; Rt_D = v.rt; Rd_D = v.rd;
        Read_Data1_D = v.rd1; Read_Data2_D = v.rd1 ^ 32'h0000_ffff;
        Sign_Imm_D = v.rd1 + 32'd4;
        Reg_Write_D = v.rw; Mem_To_Reg_D = v.mtr; Mem_Write_D = v.mw;
        ALU_Src_D = v.mtr; Reg_Dst_D = v.regdst; Branch_D = v.branch;
        ALU_Control_D = 3'd2; Write_Reg_M = v.wrm; Mem_To_Reg_M = v.mtrm;
    endtask

    task automatic quiet();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".valid_e"}, 32'(Valid_E), 0);
        chk({tag, ".ctrl_e"}, 32'({Reg_Write_E, Mem_To_Reg_E, Mem_Write_E, ALU_Src_E,
            Reg_Dst_E, ALU_Control_E}), 0);
        chk({tag, ".regs_e"}, 32'({Rs_E, Rt_E, Rd_E, Write_Reg_E}), 0);
        chk({tag, ".data_e"}, Read_Data1_E | Read_Data2_E | Sign_Imm_E, 0);
        chk({tag, ".flush"}, 32'({Stall_F, Stall_D, Flush_E}), 0);
        chk({tag, ".cnt"}, 32'(Stall_Count), 0);
        chk({tag, ".err"}, 32'(Stall_Error), 0);
    endtask

    initial begin
        //            v  rs rt rd rd1         rw m mw dst br wrm mm | f  v rw m wr rs rt rd1        cnt
        vecs[0]  = mk(1, 1, 2, 3, 32'h11,    1, 0, 0, 1, 0, 0, 0,   0, 1, 1, 0, 3, 1, 2, 32'h11,  0);
        vecs[1]  = mk(1, 1, 5, 0, 32'h100,   1, 1, 0, 0, 0, 0, 0,   0, 1, 1, 1, 5, 1, 5, 32'h100, 0);
        vecs[2]  = mk(1, 5, 6, 7, 32'haa,    1, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 32'h0,   1);
        vecs[3]  = mk(1, 5, 6, 7, 32'haa,    1, 0, 0, 1, 0, 0, 0,   0, 1, 1, 0, 7, 5, 6, 32'haa,  1);
        vecs[4]  = mk(1, 2, 0, 0, 32'h5,     1, 1, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 2, 0, 32'h5,   1);
        vecs[5]  = mk(1, 0, 0, 8, 32'h6,     1, 0, 0, 1, 0, 0, 0,   0, 1, 1, 0, 8, 0, 0, 32'h6,   1);
        vecs[6]  = mk(0, 8, 9, 10, 32'h77,   1, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 10, 8, 9, 32'h77, 1);
        vecs[7]  = mk(1, 1, 2, 7, 32'h1,     1, 0, 0, 1, 0, 0, 0,   0, 1, 1, 0, 7, 1, 2, 32'h1,   1);
        vecs[8]  = mk(1, 7, 0, 0, 32'h9,     0, 0, 0, 0, 1, 7, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0,   2);
        vecs[9]  = mk(1, 7, 0, 0, 32'h9,     0, 0, 0, 0, 1, 7, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0,   3);
        vecs[10] = mk(1, 7, 0, 0, 32'h9,     0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 7, 0, 32'h9,   3);
        vecs[11] = mk(1, 0, 4, 0, 32'h44,    1, 1, 0, 0, 0, 0, 0,   0, 1, 1, 1, 4, 0, 4, 32'h44,  3);
        vecs[12] = mk(1, 4, 4, 0, 32'h55,    0, 0, 0, 0, 1, 4, 1,   1, 0, 0, 0, 0, 0, 0, 32'h0,   4);
        vecs[13] = mk(0, 0, 0, 0, 32'h0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 32'h0,   4);

        rst = 1'b1;
        quiet();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("init");

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.flush_e", i), 32'(Flush_E), 32'(vecs[i].x_flush));
            chk($sformatf("v%0d.stall_fd", i), 32'({Stall_F, Stall_D}),
                32'({vecs[i].x_flush, vecs[i].x_flush}));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid_e", i), 32'(Valid_E), 32'(vecs[i].x_valid));
            chk($sformatf("v%0d.reg_write_e", i), 32'(Reg_Write_E), 32'(vecs[i].x_rw));
            chk($sformatf("v%0d.mem_to_reg_e", i), 32'(Mem_To_Reg_E), 32'(vecs[i].x_mtr));
            chk($sformatf("v%0d.mem_write_e", i), 32'(Mem_Write_E),
                32'(!vecs[i].x_flush & vecs[i].valid & vecs[i].mw));
            chk($sformatf("v%0d.write_reg_e", i), 32'(Write_Reg_E), 32'(vecs[i].x_wr));
            chk($sformatf("v%0d.rs_e", i), 32'(Rs_E), 32'(vecs[i].x_rs));
            chk($sformatf("v%0d.rt_e", i), 32'(Rt_E), 32'(vecs[i].x_rt));
            chk($sformatf("v%0d.rd1_e", i), Read_Data1_E, vecs[i].x_rd1);
            chk($sformatf("v%0d.rd2_e", i), Read_Data2_E,
                vecs[i].x_flush ? 32'h0 : (vecs[i].rd1 ^ 32'h0000_ffff));
            chk($sformatf("v%0d.cnt", i), 32'(Stall_Count), 32'(vecs[i].x_cnt));
            chk($sformatf("v%0d.err", i), 32'(Stall_Error), 0);
        end

        // Reset after stall activity.
        @(negedge clk);
        rst = 1'b1;
        quiet();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("rst1");
        chk("rst1.small_cnt", 32'(s_cnt), 0);

        // Timeout: M-stage load hazard on a branch held for 6 cycles.
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            drive(mk(1, 9, 0, 0, 32'h9, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            chk($sformatf("to%0d.flush_e", k), 32'(Flush_E), 1);
            @(posedge clk);
            #1;
            chk($sformatf("to%0d.cnt", k), 32'(Stall_Count), 32'(k));
            chk($sformatf("to%0d.err", k), 32'(Stall_Error), 32'(k >= 5));
            chk($sformatf("to%0d.small_cnt", k), 32'(s_cnt), 32'((k > 3) ? 3 : k));
            chk($sformatf("to%0d.valid_e", k), 32'(Valid_E), 0);
        end
        @(negedge clk);
        quiet();
        #1;
        chk("to_clr.flush_e", 32'(Flush_E), 0);
        @(posedge clk);
        #1;
        chk("to_clr.err_sticky", 32'(Stall_Error), 1);
        chk("to_clr.cnt", 32'(Stall_Count), 6);
        chk("to_clr.small_cnt", 32'(s_cnt), 3);

        // Reset while a stall is in progress.
        @(negedge clk);
        drive(mk(1, 9, 0, 0, 32'h9, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        chk("rst2.flush_pre", 32'(Flush_E), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        quiet();
        #1;
        chk_reset_state("rst2");
        chk("rst2.small_err", 32'(s_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "bench time limit expired");
    end

endmodule
